// File: rtl/sdram_pwrup_seq.sv
// SDRAM power-up sequencer: qualifies PLL lock, waits out the power-up NOP
// period, issues precharge-all / N auto-refresh / load-mode, then releases reset.
module sdram_pwrup_seq #(
  parameter int unsigned       CLK_MHZ     = 60,
  parameter int unsigned       WAIT_US     = 200,
  parameter int unsigned       LOCK_STABLE = 1024,
  parameter int unsigned       TRP         = 2,
  parameter int unsigned       TRFC        = 7,
  parameter int unsigned       TMRD        = 2,
  parameter int unsigned       N_REFRESH   = 8,
  parameter int unsigned       ADDR_W      = 11,
  parameter int unsigned       BA_W        = 2,
  parameter logic [ADDR_W-1:0] MODE_REG    = 11'h020
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_lock,
  output logic [3:0]        cmd_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [BA_W-1:0]   ba_o,
  output logic              cke_o,
  output logic              init_done,
  output logic              sys_rst_n,
  output logic              lock_lost
);

  localparam int unsigned PWR_CYC = CLK_MHZ * WAIT_US;
  localparam int unsigned MAX_AB  = (PWR_CYC > LOCK_STABLE) ? PWR_CYC : LOCK_STABLE;
  localparam int unsigned MAX_CD  = (TRP > TRFC) ? TRP : TRFC;
  localparam int unsigned MAX_T   = (MAX_CD > TMRD) ? MAX_CD : TMRD;
  localparam int unsigned CNT_MAX = (MAX_AB > MAX_T) ? MAX_AB : MAX_T;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned REF_W   = $clog2(N_REFRESH + 1);

  // Wait states last T-1 cycles, so their counters load T-2 and expire at zero.
  localparam logic [CNT_W-1:0] LD_LOCK = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] LD_PWR  = CNT_W'(PWR_CYC - 1);
  localparam logic [CNT_W-1:0] LD_TRP  = CNT_W'((TRP  > 1) ? TRP  - 2 : 0);
  localparam logic [CNT_W-1:0] LD_TRFC = CNT_W'((TRFC > 1) ? TRFC - 2 : 0);
  localparam logic [CNT_W-1:0] LD_TMRD = CNT_W'((TMRD > 1) ? TMRD - 2 : 0);
  localparam logic [REF_W-1:0] N_REF_C = REF_W'(N_REFRESH);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_LMR = 4'b0000;

  typedef enum logic [3:0] {
    S_WAIT_LOCK, S_LOCK_STABLE, S_PWR_WAIT, S_PRE, S_WAIT_TRP,
    S_REF, S_WAIT_TRFC, S_LMR, S_WAIT_TMRD, S_DONE
  } state_t;

  state_t            r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic [REF_W-1:0]  r_ref_cnt, w_ref_next, w_ref_inc;
  logic              r_lock_meta, r_lock_s;
  logic              w_cnt_zero, w_set_lost;
  logic [3:0]        r_cmd, w_cmd;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [BA_W-1:0]   r_ba, w_ba;
  logic              r_cke, w_cke, r_done, w_done, r_lock_lost;

  assign w_cnt_zero = (r_cnt == '0);
  assign w_ref_inc  = r_ref_cnt + 1'b1;
  assign w_set_lost = !r_lock_s && (r_state != S_WAIT_LOCK) && (r_state != S_LOCK_STABLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= pll_lock;
      r_lock_s    <= r_lock_meta;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_ref_next   = r_ref_cnt;
    case (r_state)
      S_WAIT_LOCK: begin
        w_cnt_next = '0;
        w_ref_next = '0;
        if (r_lock_s) begin
          w_state_next = S_LOCK_STABLE;
          w_cnt_next   = LD_LOCK;
        end
      end
      S_LOCK_STABLE: begin
        if (w_cnt_zero) begin
          w_state_next = S_PWR_WAIT;
          w_cnt_next   = LD_PWR;
        end else w_cnt_next = r_cnt - 1'b1;
      end
      S_PWR_WAIT: begin
        if (w_cnt_zero) w_state_next = S_PRE;
        else            w_cnt_next   = r_cnt - 1'b1;
      end
      S_PRE: begin
        if (TRP > 1) begin
          w_state_next = S_WAIT_TRP;
          w_cnt_next   = LD_TRP;
        end else w_state_next = S_REF;
      end
      S_WAIT_TRP: begin
        if (w_cnt_zero) w_state_next = S_REF;
        else            w_cnt_next   = r_cnt - 1'b1;
      end
      S_REF: begin
        w_ref_next = w_ref_inc;
        if (TRFC > 1) begin
          w_state_next = S_WAIT_TRFC;
          w_cnt_next   = LD_TRFC;
        end else w_state_next = (w_ref_inc < N_REF_C) ? S_REF : S_LMR;
      end
      S_WAIT_TRFC: begin
        if (w_cnt_zero) w_state_next = (r_ref_cnt < N_REF_C) ? S_REF : S_LMR;
        else            w_cnt_next   = r_cnt - 1'b1;
      end
      S_LMR: begin
        if (TMRD > 1) begin
          w_state_next = S_WAIT_TMRD;
          w_cnt_next   = LD_TMRD;
        end else w_state_next = S_DONE;
      end
      S_WAIT_TMRD: begin
        if (w_cnt_zero) w_state_next = S_DONE;
        else            w_cnt_next   = r_cnt - 1'b1;
      end
      S_DONE: ;
      default: w_state_next = S_WAIT_LOCK;
    endcase

    // Lock loss overrides any transition taken above.
    if (r_state != S_WAIT_LOCK && !r_lock_s) begin
      w_state_next = S_WAIT_LOCK;
      w_cnt_next   = '0;
      w_ref_next   = '0;
    end

    // Outputs are decoded from the next state so they register on entry.
    w_cmd  = CMD_NOP;
    w_addr = '0;
    w_ba   = '0;
    w_cke  = 1'b1;
    w_done = 1'b0;
    case (w_state_next)
      S_WAIT_LOCK, S_LOCK_STABLE: w_cke = 1'b0;
      S_PRE: begin
        w_cmd      = CMD_PRE;
        w_addr[10] = 1'b1;
      end
      S_REF: w_cmd = CMD_REF;
      S_LMR: begin
        w_cmd  = CMD_LMR;
        w_addr = MODE_REG;
      end
      S_DONE:  w_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_WAIT_LOCK;
      r_cnt       <= '0;
      r_ref_cnt   <= '0;
      r_cmd       <= CMD_NOP;
      r_addr      <= '0;
      r_ba        <= '0;
      r_cke       <= 1'b0;
      r_done      <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_ref_cnt   <= w_ref_next;
      r_cmd       <= w_cmd;
      r_addr      <= w_addr;
      r_ba        <= w_ba;
      r_cke       <= w_cke;
      r_done      <= w_done;
      r_lock_lost <= r_lock_lost | w_set_lost;
    end
  end

  assign cmd_o     = r_cmd;
  assign addr_o    = r_addr;
  assign ba_o      = r_ba;
  assign cke_o     = r_cke;
  assign init_done = r_done;
  assign sys_rst_n = r_done;
  assign lock_lost = r_lock_lost;

endmodule

// File: tb/tb_sdram_pwrup_seq.sv
// Directed bench for sdram_pwrup_seq: a short-timing instance for the
// sequencing/lock-loss/reset cases and a default-parameter instance.
module tb_sdram_pwrup_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, lock_a, lock_b;
  logic [3:0]  cmd_a, cmd_b;
  logic [10:0] addr_a, addr_b;
  logic [1:0]  ba_a, ba_b;
  logic        cke_a, done_a, srst_a, lost_a;
  logic        cke_b, done_b, srst_b, lost_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  sdram_pwrup_seq #(
    .CLK_MHZ(1), .WAIT_US(10), .LOCK_STABLE(4), .TRP(2), .TRFC(7), .TMRD(2), .N_REFRESH(2)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .pll_lock(lock_a), .cmd_o(cmd_a), .addr_o(addr_a),
    .ba_o(ba_a), .cke_o(cke_a), .init_done(done_a), .sys_rst_n(srst_a), .lock_lost(lost_a)
  );

  sdram_pwrup_seq dut_b (
    .clk(clk), .rst_n(rst_n), .pll_lock(lock_b), .cmd_o(cmd_b), .addr_o(addr_b),
    .ba_o(ba_b), .cke_o(cke_b), .init_done(done_b), .sys_rst_n(srst_b), .lock_lost(lost_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Hand-derived timeline for the short-timing instance, cycle 0 = first lock sample.
  function automatic logic [19:0] exp_vec(input int c);
    logic [3:0]  cmd;
    logic [10:0] addr;
    logic        cke, done;
    cmd  = 4'b0111;
    addr = '0;
    if (c == 16) begin
      cmd  = 4'b0010;
      addr = 11'h400;
    end else if (c == 18 || c == 25) begin
      cmd = 4'b0001;
    end else if (c == 32) begin
      cmd  = 4'b0000;
      addr = 11'h020;
    end
    cke  = (c >= 6);
    done = (c >= 34);
    return {cmd, addr, 2'b00, cke, done, done};
  endfunction

  task automatic run_nominal(input string tag, input int upto);
    while (cyc < upto) begin
      tick();
      check_eq($sformatf("%s c%0d", tag, cyc),
               {12'h0, cmd_a, addr_a, ba_a, cke_a, done_a, srst_a}, {12'h0, exp_vec(cyc)});
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, " cmd"},  cmd_a,  4'b0111);
    check_eq({tag, " addr"}, addr_a, 0);
    check_eq({tag, " ba"},   ba_a,   0);
    check_eq({tag, " cke"},  cke_a,  0);
    check_eq({tag, " done"}, done_a, 0);
    check_eq({tag, " srst"}, srst_a, 0);
    check_eq({tag, " lost"}, lost_a, 0);
  endtask

  task automatic apply_reset;
    lock_a = 1'b0;
    lock_b = 1'b0;
    rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  int cke_rise, pre_c, first_ref, last_ref, lmr_c, done_c, nref, gap_bad;
  logic [10:0] pre_addr, lmr_addr;

  initial begin
    rst_n  = 1'b0;
    lock_a = 1'b0;
    lock_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    rst_n = 1'b1;
    repeat (3) tick();

    // Nominal sequence
    lock_a = 1'b1;
    cyc = -1;
    run_nominal("s1", 36);
    check_eq("s1 lost", lost_a, 0);

    // Lock drop 5 cycles after init_done
    while (cyc < 38) tick();
    lock_a = 1'b0;
    while (cyc < 40) tick();
    check_eq("s4 done held", done_a, 1);
    while (cyc < 42) tick();
    check_eq("s4 done", done_a, 0);
    check_eq("s4 srst", srst_a, 0);
    check_eq("s4 cke",  cke_a,  0);
    check_eq("s4 lost", lost_a, 1);

    // Lock bounce during qualification
    apply_reset();
    lock_a = 1'b1;
    cyc = -1;
    while (cyc < 12) begin
      tick();
      if (cyc == 2) lock_a = 1'b0;
      if (cyc == 4) lock_a = 1'b1;
      check_eq($sformatf("s2 cke c%0d", cyc), cke_a, (cyc >= 11) ? 1 : 0);
    end
    while (cyc < 21) tick();
    check_eq("s2 pre", cmd_a, 4'b0010);
    check_eq("s2 lost", lost_a, 0);

    // Lock drop during WAIT_TRFC, then relock
    apply_reset();
    lock_a = 1'b1;
    cyc = -1;
    run_nominal("s3a", 19);
    lock_a = 1'b0;
    while (cyc < 21) tick();
    check_eq("s3 lost early", lost_a, 0);
    check_eq("s3 cke early",  cke_a,  1);
    while (cyc < 23) tick();
    check_eq("s3 cke",  cke_a,  0);
    check_eq("s3 cmd",  cmd_a,  4'b0111);
    check_eq("s3 lost", lost_a, 1);
    lock_a = 1'b1;
    cyc = -1;
    run_nominal("s3b", 36);
    check_eq("s3 lost held", lost_a, 1);

    // Asynchronous reset pulse mid-sequence with lock held
    apply_reset();
    lock_a = 1'b1;
    cyc = -1;
    run_nominal("s5a", 12);
    rst_n = 1'b0;
    #1;
    check_reset_vals("s5 async");
    #4;
    rst_n = 1'b1;
    cyc = -1;
    run_nominal("s5b", 36);
    check_eq("s5 lost", lost_a, 0);

    // Default-parameter instance
    apply_reset();
    lock_b = 1'b1;
    cyc = -1;
    cke_rise = -1; pre_c = -1; first_ref = -1; last_ref = -1;
    lmr_c = -1; done_c = -1; nref = 0; gap_bad = 0;
    pre_addr = '0; lmr_addr = '0;
    while (done_c < 0 && cyc < 14000) begin
      tick();
      if (cke_b && cke_rise < 0) cke_rise = cyc;
      if (cmd_b == 4'b0010) begin
        pre_c = cyc;
        pre_addr = addr_b;
      end
      if (cmd_b == 4'b0001) begin
        if (first_ref < 0) first_ref = cyc;
        else if (cyc - last_ref != 7) gap_bad++;
        last_ref = cyc;
        nref++;
      end
      if (cmd_b == 4'b0000) begin
        lmr_c = cyc;
        lmr_addr = addr_b;
      end
      if (done_b && srst_b) done_c = cyc;
    end
    check_eq("s6 done seen",  (done_c >= 0) ? 1 : 0, 1);
    check_eq("s6 cke rise",   cke_rise, 1026);
    check_eq("s6 pre gap",    pre_c - cke_rise, 12000);
    check_eq("s6 pre a10",    pre_addr, 11'h400);
    check_eq("s6 pre->ref",   first_ref - pre_c, 2);
    check_eq("s6 ref count",  nref, 8);
    check_eq("s6 ref gaps",   gap_bad, 0);
    check_eq("s6 ref->lmr",   lmr_c - last_ref, 7);
    check_eq("s6 lmr addr",   lmr_addr, 11'h020);
    check_eq("s6 lmr->done",  done_c - lmr_c, 2);
    check_eq("s6 lost",       lost_b, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_pwrup_seq.md
Name: sdram_pwrup_seq

Overview:
- Sits directly downstream of the SDRAM-clock PLL: 27 MHz in, 60 MHz out, with a lock output.
- Qualifies the PLL lock, holds the embedded SDRAM through its power-up wait, then issues the JEDEC init sequence: precharge-all, N auto-refreshes, load-mode-register.
- When the sequence completes, it releases the system reset to the SDRAM controller and hands over the command bus.
- Any loss of PLL lock aborts the sequence and restarts it.

Parameters:
- CLK_MHZ, 60, SDRAM clock frequency in MHz; power-up wait = CLK_MHZ*WAIT_US cycles.
- WAIT_US, 200, power-up NOP wait in microseconds.
- LOCK_STABLE, 1024, cycles the synchronized lock must stay high before the sequence starts.
- TRP, 2, precharge-to-next-command spacing in cycles (>=1).
- TRFC, 7, refresh-to-next-command spacing in cycles (>=1).
- TMRD, 2, mode-register-to-done spacing in cycles (>=1).
- N_REFRESH, 8, number of auto-refresh commands (>=1).
- ADDR_W, 11, SDRAM address width.
- BA_W, 2, bank address width.
- MODE_REG, 11'h020, mode word (CAS 2, sequential, burst 1).

Ports:
- clk  in  1  SDRAM clock (PLL clkout).
- rst_n  in  1  asynchronous active-low reset.
- pll_lock  in  1  raw PLL lock, asynchronous to clk.
- cmd_o  out  4  {cs_n,ras_n,cas_n,we_n}.
- addr_o  out  ADDR_W  SDRAM address.
- ba_o  out  BA_W  bank address.
- cke_o  out  1  SDRAM clock enable.
- init_done  out  1  init sequence complete.
- sys_rst_n  out  1  active-low reset to downstream controller.
- lock_lost  out  1  sticky flag: lock dropped after once qualified.

Behaviour:
- Reset values (rst_n=0, asynchronous): cmd_o=4'b0111 (NOP), addr_o=0, ba_o=0, cke_o=0, init_done=0, sys_rst_n=0, lock_lost=0, state=WAIT_LOCK, all counters 0.
- pll_lock passes through a 2-FF synchronizer (lock_s) with 2-cycle latency. All decisions use lock_s only.
- Command encodings:
  - NOP = 0111
  - PRECHARGE = 0010, with addr_o[10]=1 (all banks)
  - AUTO_REFRESH = 0001
  - LOAD_MODE = 0000, with addr_o=MODE_REG and ba_o=0
  - addr_o and ba_o are 0 for every command other than PRECHARGE and LOAD_MODE.
- State machine:
  - WAIT_LOCK: NOP, cke_o=0. Go to LOCK_STABLE when lock_s=1.
  - LOCK_STABLE: counts LOCK_STABLE cycles with lock_s high, then PWR_WAIT.
  - PWR_WAIT: cke_o=1, NOP for exactly CLK_MHZ*WAIT_US cycles, then PRE.
  - PRE: one cycle of PRECHARGE, then WAIT_TRP.
  - WAIT_TRP: NOP for TRP-1 cycles, then REF.
  - REF: one cycle of AUTO_REFRESH; refresh counter increments.
  - WAIT_TRFC: NOP for TRFC-1 cycles. Go to REF if count<N_REFRESH, else LMR.
  - LMR: one cycle of LOAD_MODE, then WAIT_TMRD.
  - WAIT_TMRD: NOP for TMRD-1 cycles, then DONE.
  - DONE: init_done=1, sys_rst_n=1, cke_o=1, cmd_o=NOP, addr_o=0. Terminal while lock_s=1.
- Spacing rule: command-to-next-command spacing is exactly TRP, TRFC and TMRD cycles respectively. Each waiting phase uses a single down-counter sized to the largest of CLK_MHZ*WAIT_US, LOCK_STABLE, TRP, TRFC and TMRD.
- All outputs are registered and change on the clock edge that enters the new state.
- Lock loss: lock_s=0 in any state other than WAIT_LOCK forces, on the next edge:
  - state=WAIT_LOCK
  - cke_o=0, cmd_o=NOP, init_done=0, sys_rst_n=0
  - counters cleared
  - lock_lost=1 if the state was PWR_WAIT or later. lock_lost then holds until rst_n.
  - This has priority over any simultaneous counter expiry or state transition.
- Lock bounce during LOCK_STABLE returns to WAIT_LOCK without setting lock_lost, and the qualification count restarts from 0.
- rst_n assertion mid-sequence immediately returns all outputs to their reset values. After rst_n is released, the sequence restarts from WAIT_LOCK.

Test Plan:
Scenarios 1-4 use CLK_MHZ=1, WAIT_US=10, LOCK_STABLE=4, TRP=2, TRFC=7, TMRD=2, N_REFRESH=2. Cycle 0 is the first edge that samples pll_lock=1.
1. Nominal sequence -> required response:
   - lock_s=1 at cycle 2; cke_o rises at cycle 6.
   - PRECHARGE with addr_o[10]=1 at cycle 16.
   - AUTO_REFRESH at cycles 18 and 25.
   - LOAD_MODE with addr_o=11'h020 at cycle 32.
   - init_done=sys_rst_n=1 at cycle 34.
   - NOP on every other cycle.
2. pll_lock pulses high 3 cycles, low 2, then high steady -> no cke_o until 4 consecutive lock_s-high cycles; lock_lost stays 0.
3. pll_lock drops at cycle 20, during WAIT_TRFC -> by cycle 23: cke_o=0, cmd_o=NOP, lock_lost=1. Relock reruns the full sequence; lock_lost still 1 after the second init_done.
4. pll_lock drops 5 cycles after init_done -> init_done=0 and sys_rst_n=0 within 3 cycles, lock_lost=1.
5. rst_n pulsed low for half a cycle at cycle 12 -> every output is at its reset value asynchronously. With lock held, the sequence restarts and completes 34 cycles after the first post-reset edge that samples lock.
6. Default parameters -> PRECHARGE occurs 12000 cycles after cke_o rises; exactly 8 AUTO_REFRESH commands spaced 7 cycles apart; LOAD_MODE to init_done spacing is 2 cycles.
